// File: rtl/sc_gamefsm_pkg.sv
// Shared definitions for the game-flow controller: state encoding and game limits.
package sc_gamefsm_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StPlay     = 3'd1,
        StHit      = 3'd2,
        StRespawn  = 3'd3,
        StLevelUp  = 3'd4,
        StGameOver = 3'd5
    } state_e;

    localparam int unsigned LIVES_INIT_DEFAULT = 3;
    localparam logic [2:0]  LEVEL_MAX          = 3'd7;

    function automatic logic [2:0] level_inc(input logic [2:0] level);
        return (level == LEVEL_MAX) ? level : level + 3'd1;
    endfunction

endpackage

// File: rtl/sc_tickcounter.sv
// Tick-qualified counter: advances on enabled ticks, wraps to zero on the limit-th tick
// and flags that tick combinationally so the owner can register a one-cycle response.
module sc_tickcounter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic             tick_i,
    input  logic [Width-1:0] limit_i,
    output logic             tc_o
);

    logic [Width-1:0] count_q, count_d;
    logic             step;

    always_comb begin
        step    = enable_i & tick_i;
        tc_o    = step & (count_q == limit_i - Width'(1));
        count_d = count_q;
        if (clear_i || tc_o) begin
            count_d = '0;
        end else if (step) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sc_gamefsm.sv
// Game-flow controller: sequences idle/play/hit/respawn/level-up/game-over, paces lane
// shifts by level and drives registered control pulses to the frog and lane datapath.
module sc_gamefsm
    import sc_gamefsm_pkg::*;
#(
    parameter int unsigned FREEZE_TICKS = 4,
    parameter int unsigned GRACE_TICKS  = 6,
    parameter int unsigned LIVES_INIT   = LIVES_INIT_DEFAULT
) (
    input  logic       SC_GAMEFSM_CLOCK_50,
    input  logic       SC_GAMEFSM_RESET_InHigh,
    input  logic       SC_GAMEFSM_Start_InLow,
    input  logic       SC_GAMEFSM_Tick_InHigh,
    input  logic       SC_GAMEFSM_Lose_InHigh,
    input  logic       SC_GAMEFSM_TopRow_InHigh,
    output logic       SC_GAMEFSM_NN_OutLow,
    output logic       SC_GAMEFSM_FrogLoad_OutHigh,
    output logic       SC_GAMEFSM_LaneShift_OutHigh,
    output logic [1:0] SC_GAMEFSM_Lives_Out,
    output logic [2:0] SC_GAMEFSM_Level_Out,
    output logic [2:0] SC_GAMEFSM_State_Out,
    output logic       SC_GAMEFSM_GameOver_OutHigh
);

    state_e     state_q;
    logic [1:0] lives_q;
    logic [2:0] level_q;
    logic       nn_q, frog_load_q, lane_shift_q, game_over_q;

    logic       shift_en, shift_clr, shift_tc;
    logic [3:0] shift_limit;
    logic       phase_en, phase_clr, phase_tc;
    logic [7:0] phase_limit;

    always_comb begin
        // The tick that causes PLAY->HIT is swallowed so the lanes freeze on that very step.
        shift_en    = ((state_q == StPlay) && !SC_GAMEFSM_Lose_InHigh) ||
                      (state_q == StRespawn);
        shift_clr   = !((state_q == StPlay) || (state_q == StRespawn) || (state_q == StHit));
        shift_limit = 4'd8 - {1'b0, level_q};
        phase_en    = (state_q == StHit) || (state_q == StRespawn);
        phase_clr   = !phase_en;
        phase_limit = (state_q == StHit) ? 8'(FREEZE_TICKS) : 8'(GRACE_TICKS);
    end

    sc_tickcounter #(
        .Width (4)
    ) u_shift_cnt (
        .clk_i    (SC_GAMEFSM_CLOCK_50),
        .rst_i    (SC_GAMEFSM_RESET_InHigh),
        .clear_i  (shift_clr),
        .enable_i (shift_en),
        .tick_i   (SC_GAMEFSM_Tick_InHigh),
        .limit_i  (shift_limit),
        .tc_o     (shift_tc)
    );

    sc_tickcounter #(
        .Width (8)
    ) u_phase_cnt (
        .clk_i    (SC_GAMEFSM_CLOCK_50),
        .rst_i    (SC_GAMEFSM_RESET_InHigh),
        .clear_i  (phase_clr),
        .enable_i (phase_en),
        .tick_i   (SC_GAMEFSM_Tick_InHigh),
        .limit_i  (phase_limit),
        .tc_o     (phase_tc)
    );

    // Outputs are computed for the state being entered, so they line up with State_Out.
    always_ff @(posedge SC_GAMEFSM_CLOCK_50) begin
        if (SC_GAMEFSM_RESET_InHigh) begin
            state_q      <= StIdle;
            lives_q      <= 2'(LIVES_INIT);
            level_q      <= '0;
            nn_q         <= 1'b1;
            frog_load_q  <= 1'b0;
            lane_shift_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            frog_load_q  <= 1'b0;
            lane_shift_q <= shift_tc;
            case (state_q)
                StIdle: begin
                    lives_q     <= 2'(LIVES_INIT);
                    level_q     <= '0;
                    nn_q        <= 1'b1;
                    game_over_q <= 1'b0;
                    if (!SC_GAMEFSM_Start_InLow) begin
                        state_q     <= StPlay;
                        frog_load_q <= 1'b1;
                        nn_q        <= 1'b0;
                    end
                end
                StPlay: begin
                    if (SC_GAMEFSM_Lose_InHigh) begin
                        state_q <= StHit;
                        nn_q    <= 1'b1;
                        if (lives_q != 2'd0) begin
                            lives_q <= lives_q - 2'd1;
                        end
                    end else if (SC_GAMEFSM_TopRow_InHigh) begin
                        state_q     <= StLevelUp;
                        nn_q        <= 1'b1;
                        level_q     <= level_inc(level_q);
                        frog_load_q <= 1'b1;
                    end
                end
                StHit: begin
                    if (phase_tc) begin
                        if (lives_q == 2'd0) begin
                            state_q     <= StGameOver;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q     <= StRespawn;
                            frog_load_q <= 1'b1;
                        end
                    end
                end
                StRespawn: begin
                    if (phase_tc) begin
                        state_q <= StPlay;
                        nn_q    <= 1'b0;
                    end
                end
                StLevelUp: begin
                    state_q <= StRespawn;
                end
                StGameOver: begin
                    if (SC_GAMEFSM_Start_InLow) begin
                        state_q     <= StIdle;
                        game_over_q <= 1'b0;
                        lives_q     <= 2'(LIVES_INIT);
                        level_q     <= '0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    lives_q     <= 2'(LIVES_INIT);
                    level_q     <= '0;
                    nn_q        <= 1'b1;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign SC_GAMEFSM_NN_OutLow         = nn_q;
    assign SC_GAMEFSM_FrogLoad_OutHigh  = frog_load_q;
    assign SC_GAMEFSM_LaneShift_OutHigh = lane_shift_q;
    assign SC_GAMEFSM_Lives_Out         = lives_q;
    assign SC_GAMEFSM_Level_Out         = level_q;
    assign SC_GAMEFSM_State_Out         = state_q;
    assign SC_GAMEFSM_GameOver_OutHigh  = game_over_q;

endmodule

// File: doc/sc_gamefsm.md
SC_GAMEFSM -- requirements
Module: sc_gamefsm

Interface
REQ-001 Parameter FREEZE_TICKS, default 4: game ticks spent frozen in HIT after a collision.
REQ-002 Parameter GRACE_TICKS, default 6: game ticks of collision immunity in RESPAWN.
REQ-003 Parameter LIVES_INIT, default 3: lives loaded on game start; range 1..3.
REQ-004 Port SC_GAMEFSM_CLOCK_50  in  1  single system clock; all state changes on its rising edge.
REQ-005 Port SC_GAMEFSM_RESET_InHigh  in  1  reset; synchronous, active-high.
REQ-006 Port SC_GAMEFSM_Start_InLow  in  1  start button, active-low, debounced upstream.
REQ-007 Port SC_GAMEFSM_Tick_InHigh  in  1  one-cycle game-step strobe.
REQ-008 Port SC_GAMEFSM_Lose_InHigh  in  1  collision flag from the lane/frog collision comparator.
REQ-009 Port SC_GAMEFSM_TopRow_InHigh  in  1  frog occupies goal row.
REQ-010 Port SC_GAMEFSM_NN_OutLow  out  1  collision mask to comparator: 0 = detection enabled, 1 = suppressed.
REQ-011 Port SC_GAMEFSM_FrogLoad_OutHigh  out  1  one-cycle pulse: reload frog register to start position.
REQ-012 Port SC_GAMEFSM_LaneShift_OutHigh  out  1  one-cycle pulse: rotate lane registers.
REQ-013 Port SC_GAMEFSM_Lives_Out  out  2  remaining lives.
REQ-014 Port SC_GAMEFSM_Level_Out  out  3  current level, 0..7.
REQ-015 Port SC_GAMEFSM_State_Out  out  3  state code: IDLE=0, PLAY=1, HIT=2, RESPAWN=3, LEVELUP=4, GAMEOVER=5.
REQ-016 Port SC_GAMEFSM_GameOver_OutHigh  out  1  high exactly while in GAMEOVER.

Function
REQ-017 All outputs SHALL be registered; each response appears one cycle after the causing input is sampled.
REQ-018 IDLE: Lives=LIVES_INIT, Level=0, NN=1, no shifts; Start_InLow=0 -> PLAY with FrogLoad pulse.
REQ-019 PLAY: NN=0; Lose=1 -> HIT and Lives decrements by 1; else TopRow=1 -> LEVELUP.
REQ-020 Lose and TopRow high in the same cycle: Lose SHALL win.
REQ-021 Lane shift period SHALL be (8 - Level) ticks; in PLAY and RESPAWN a shift counter counts Tick strobes and pulses LaneShift on the period-th tick, then clears.
REQ-022 Tick coinciding with a PLAY->HIT transition SHALL NOT produce a LaneShift pulse.
REQ-023 HIT: NN=1, lanes frozen, shift counter held; after FREEZE_TICKS ticks -> GAMEOVER if Lives=0, else RESPAWN with FrogLoad pulse.
REQ-024 RESPAWN: NN=1, lanes shift; after GRACE_TICKS ticks -> PLAY.
REQ-025 LEVELUP: single cycle; Level increments, saturating at 7; FrogLoad pulse; shift counter cleared; -> RESPAWN.
REQ-026 GAMEOVER: NN=1, GameOver=1, Lives=0, Level held; Start_InLow=1 (released) -> IDLE.
REQ-027 Lives SHALL never underflow; decrement only on PLAY->HIT.
REQ-028 FrogLoad and LaneShift SHALL each be exactly one cycle wide, never held.
REQ-029 Undefined state codes 6,7 SHALL return to IDLE on the next edge.

Reset
REQ-030 With RESET_InHigh=1 at an edge, the block SHALL enter IDLE with Lives=LIVES_INIT, Level=0, NN=1, pulses 0, GameOver=0, all counters 0, regardless of current state.
REQ-031 Reset SHALL take priority over every other input, including mid-HIT or mid-RESPAWN.

Structure
REQ-032 Package sc_gamefsm_pkg SHALL hold the state encoding, LIVES_INIT default and LEVEL_MAX=7.
REQ-033 One sub-module, sc_tickcounter (tick-qualified counter with clear and terminal-count flag), SHALL be instantiated for the shift counter and the freeze/grace counter.

Verification
REQ-034 Reset, Start_InLow=0 one cycle -> State=1, FrogLoad pulse, NN=0, Lives=3.
REQ-035 PLAY, Level=0, 16 ticks -> exactly 2 LaneShift pulses, on ticks 8 and 16.
REQ-036 PLAY, Lose=1 and TopRow=1 same cycle -> State=2, Lives 3->2, Level unchanged, no shift; after 4 ticks State=3 with FrogLoad; after 6 more ticks State=1.
REQ-037 Three collisions -> after third freeze State=5, GameOver=1, Lives=0; Start held low stays 5; release -> State=0.
REQ-038 Eight TopRow events -> Level saturates at 7, shift period 1 tick (pulse every tick).
REQ-039 Reset asserted mid-HIT -> next edge State=0, Lives=3, counters clear, no pulses.
